// File: rtl/field_serializer_pkg.sv
// Shared types for the field serializer: table entry layout, field types,
// protobuf wire types and key construction.
package field_serializer_pkg;

  localparam int FIELD_ID_W = 29;
  localparam int OFFSET_W   = 16;

  typedef enum logic [1:0] {
    FT_VARINT64 = 2'd0,
    FT_SINT64   = 2'd1,
    FT_FIXED32  = 2'd2,
    FT_FIXED64  = 2'd3
  } field_type_e;

  typedef struct packed {
    logic [FIELD_ID_W-1:0] field_id;
    logic [OFFSET_W-1:0]   offset;
    logic                  nested;
    field_type_e           ftype;
  } TABLE_ENTRY;

  localparam logic [2:0] WT_VARINT = 3'd0;
  localparam logic [2:0] WT_I64    = 3'd1;
  localparam logic [2:0] WT_I32    = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_KEY   = 3'd2,
    S_VAL   = 3'd3,
    S_DONE  = 3'd4
  } ser_state_e;

  function automatic logic [2:0] wire_type(input field_type_e ft);
    case (ft)
      FT_FIXED64: return WT_I64;
      FT_FIXED32: return WT_I32;
      default:    return WT_VARINT;
    endcase
  endfunction

  // Key is (field_id << 3) | wire_type; a 29-bit id keeps it within 32 bits.
  function automatic logic [63:0] key_value(input logic [FIELD_ID_W-1:0] fid,
                                            input field_type_e ft);
    return {32'd0, fid, wire_type(ft)};
  endfunction

endpackage

// File: rtl/field_serializer_if.sv
// Bus bundle between the object buffer / memory / byte sink and the serializer.
// master = serializer side, slave = environment side.
interface field_serializer_if #(
  parameter int ADDR_W = 64
);
  import field_serializer_pkg::*;

  TABLE_ENTRY        entry;
  logic              entry_valid;
  logic [ADDR_W-1:0] cpp_base_addr;
  logic              ser_ready;
  logic              ser_done;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rvalid;
  logic [63:0]       mem_rdata;
  logic [7:0]        out_byte;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  entry, entry_valid, cpp_base_addr, mem_rvalid, mem_rdata, out_ready,
    output ser_ready, ser_done, mem_req, mem_addr, out_byte, out_valid
  );

  modport slave (
    output entry, entry_valid, cpp_base_addr, mem_rvalid, mem_rdata, out_ready,
    input  ser_ready, ser_done, mem_req, mem_addr, out_byte, out_valid
  );

endinterface

// File: rtl/field_serializer_varint_emitter.sv
// Byte shifter shared by key and value emission. Loads a 64-bit value in
// either varint mode (7 bits per byte, continuation bit) or fixed mode
// (N bytes LSB first) and presents one registered byte per valid/ready beat.
// A load may coincide with acceptance of the previous last byte so that
// consecutive loads produce no bubble.
module field_serializer_varint_emitter (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [63:0] load_value,
  input  logic        load_fixed,
  input  logic [3:0]  load_nbytes,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready
);

  logic [63:0] rest_q;
  logic        fixed_q;
  logic [3:0]  left_q;

  logic [63:0] src;
  logic        src_fixed;
  logic [3:0]  src_left;
  logic [7:0]  head;
  logic        head_last;
  logic [63:0] tail;
  logic [3:0]  tail_left;
  logic        advance;

  assign advance = load || (out_valid && out_ready && !out_last);

  // Next byte to present: taken from a fresh load or from the remaining value.
  always_comb begin
    src       = load ? load_value  : rest_q;
    src_fixed = load ? load_fixed  : fixed_q;
    src_left  = load ? load_nbytes : left_q;
    head      = 8'd0;
    head_last = 1'b0;
    tail      = 64'd0;
    tail_left = src_left;
    if (src_fixed) begin
      head      = src[7:0];
      tail      = src >> 8;
      head_last = (src_left <= 4'd1);
      tail_left = src_left - 4'd1;
    end else begin
      tail      = src >> 7;
      head_last = (tail == 64'd0);
      head      = {~head_last, src[6:0]};
    end
  end

  // Output byte register: held while stalled, dropped after the last beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_byte  <= 8'd0;
      out_last  <= 1'b0;
    end else if (advance) begin
      out_valid <= 1'b1;
      out_byte  <= head;
      out_last  <= head_last;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Remaining-value shift register; pure datapath, no reset needed.
  always_ff @(posedge clk) begin
    if (advance) begin
      rest_q  <= tail;
      left_q  <= tail_left;
      fixed_q <= src_fixed;
    end
  end

endmodule

// File: rtl/field_serializer.sv
// Serializes one table entry at a time into protobuf wire bytes: fetches the
// field value from the C++ object, emits the key varint, then the value
// (varint, zigzag varint, fixed32 or fixed64), then pulses ser_done.
module field_serializer
  import field_serializer_pkg::*;
#(
  parameter int ADDR_W        = 64,
  parameter bit SKIP_DEFAULTS = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  field_serializer_if.master bus
);

  ser_state_e            state, state_nxt;
  logic [FIELD_ID_W-1:0] field_id_q;
  field_type_e           ftype_q;
  logic [63:0]           value_q;
  logic [ADDR_W-1:0]     mem_addr_q;
  logic                  key_loaded_q;
  logic [63:0]           fetched;

  logic                  em_load;
  logic [63:0]           em_value;
  logic                  em_fixed;
  logic [3:0]            em_nbytes;
  logic [7:0]            em_byte;
  logic                  em_valid;
  logic                  em_last;
  logic                  accept_last;

  function automatic logic [63:0] zigzag(input logic signed [63:0] v);
    logic signed [63:0] z;
    z = (v <<< 1) ^ (v >>> 63);
    return $unsigned(z);
  endfunction

  // Value as it will be encoded: sint64 is zigzagged, fixed32 keeps 32 bits.
  function automatic logic [63:0] field_value(input field_type_e ft,
                                              input logic [63:0] raw);
    case (ft)
      FT_SINT64:  return zigzag($signed(raw));
      FT_FIXED32: return {32'd0, raw[31:0]};
      default:    return raw;
    endcase
  endfunction

  assign fetched     = field_value(ftype_q, bus.mem_rdata);
  assign accept_last = em_valid && bus.out_ready && em_last;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Control registers: read address and key-loaded flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr_q   <= '0;
      key_loaded_q <= 1'b0;
    end else begin
      if (state == S_IDLE && bus.entry_valid)
        mem_addr_q <= bus.cpp_base_addr + ADDR_W'(bus.entry.offset);
      key_loaded_q <= (state == S_KEY);
    end
  end

  // Datapath latches: entry descriptor in IDLE, encoded value in FETCH.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && bus.entry_valid) begin
      field_id_q <= bus.entry.field_id;
      ftype_q    <= bus.entry.ftype;
    end
    if (state == S_FETCH && bus.mem_rvalid)
      value_q <= fetched;
  end

  // Next-state logic and emitter load control.
  always_comb begin
    state_nxt = state;
    em_load   = 1'b0;
    em_value  = 64'd0;
    em_fixed  = 1'b0;
    em_nbytes = 4'd0;
    case (state)
      S_IDLE: begin
        if (bus.entry_valid)
          state_nxt = (bus.entry.field_id == '0 || bus.entry.nested) ? S_DONE : S_FETCH;
      end
      S_FETCH: begin
        if (bus.mem_rvalid)
          state_nxt = (SKIP_DEFAULTS && fetched == 64'd0) ? S_DONE : S_KEY;
      end
      S_KEY: begin
        if (!key_loaded_q) begin
          em_load  = 1'b1;
          em_value = key_value(field_id_q, ftype_q);
        end else if (accept_last) begin
          // Value loads on the same edge the last key byte leaves: no bubble.
          em_load   = 1'b1;
          em_value  = value_q;
          state_nxt = S_VAL;
          case (ftype_q)
            FT_FIXED64: begin em_fixed = 1'b1; em_nbytes = 4'd8; end
            FT_FIXED32: begin em_fixed = 1'b1; em_nbytes = 4'd4; end
            default:    begin em_fixed = 1'b0; em_nbytes = 4'd0; end
          endcase
        end
      end
      S_VAL: begin
        if (accept_last) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  field_serializer_varint_emitter u_emitter (
    .clk         (clk),
    .reset       (reset),
    .load        (em_load),
    .load_value  (em_value),
    .load_fixed  (em_fixed),
    .load_nbytes (em_nbytes),
    .out_byte    (em_byte),
    .out_valid   (em_valid),
    .out_last    (em_last),
    .out_ready   (bus.out_ready)
  );

  assign bus.ser_ready = (state == S_IDLE);
  assign bus.ser_done  = (state == S_DONE);
  assign bus.mem_req   = (state == S_FETCH);
  assign bus.mem_addr  = mem_addr_q;
  assign bus.out_byte  = em_byte;
  assign bus.out_valid = em_valid;

endmodule

// File: tb/tb_field_serializer.sv
// Scoreboard bench for field_serializer: stimulus pushes expected wire bytes
// and a done token; an independent monitor pops and compares on every
// accepted byte and every ser_done pulse.
module tb_field_serializer;
  import field_serializer_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  field_serializer_if #(.ADDR_W(64)) bus ();

  field_serializer #(.ADDR_W(64), .SKIP_DEFAULTS(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [8:0] DONE_TOK = 9'h100;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  int          mem_delay  = 1;
  logic [63:0] mem_value  = 64'd0;
  logic [63:0] exp_addr   = 64'd0;
  bit          mem_hold   = 1'b0;
  bit          late_pulse = 1'b0;
  int          mem_cnt    = 0;

  always @(posedge clk) begin
    bus.mem_rvalid <= 1'b0;
    if (late_pulse) begin
      bus.mem_rvalid <= 1'b1;
      bus.mem_rdata  <= 64'h55;
    end else if (reset) begin
      mem_cnt <= 0;
    end else if (bus.mem_req && !bus.mem_rvalid && !mem_hold) begin
      if (mem_cnt + 1 >= mem_delay) begin
        bus.mem_rvalid <= 1'b1;
        bus.mem_rdata  <= mem_value;
        mem_cnt        <= 0;
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end
  end

  // ---------------- out_ready driver ----------------
  int ready_mode = 0;  // 0: always 1, 1: toggle, 2: random
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ~bus.out_ready;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int         done_cnt = 0;
  int         mem_reqs = 0;
  logic       prev_req = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte = 8'd0;

  task automatic pop_check(input string name, input logic [8:0] act);
    logic [8:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected output %0h with empty scoreboard", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", name, act, e);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
        prev_req   = 1'b0;
      end else begin
        if (prev_stall)
          check("stall_hold", {55'd0, bus.out_valid, bus.out_byte}, {55'd0, 1'b1, prev_byte});
        if (bus.out_valid && bus.out_ready) pop_check("byte", {1'b0, bus.out_byte});
        if (bus.ser_done) begin
          pop_check("done", DONE_TOK);
          done_cnt++;
        end
        if (bus.mem_req && !prev_req) mem_reqs++;
        if (bus.mem_req && bus.mem_rvalid) check("mem_addr", bus.mem_addr, exp_addr);
        prev_req   = bus.mem_req;
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_byte  = bus.out_byte;
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic push_varint(inout logic [8:0] q[$], input logic [63:0] v);
    logic [63:0] x;
    x = v;
    do begin
      if (x / 128 != 0) q.push_back(9'(x % 128 + 128));
      else              q.push_back(9'(x % 128));
      x = x / 128;
    end while (x != 0);
  endtask

  task automatic model(input logic [28:0] fid, input logic nst, input field_type_e ft,
                       input logic [63:0] raw, output logic [8:0] q[$], output int need_mem);
    logic [63:0] v;
    logic [63:0] wt;
    int          nfix;
    q.delete();
    need_mem = 0;
    if (fid == 0 || nst) return;
    need_mem = 1;
    nfix = 0;
    case (ft)
      FT_SINT64: begin
        wt = 0;
        if (raw[63]) v = 2 * (64'd0 - raw) - 1;  // negative n -> 2|n|-1
        else         v = 2 * raw;
      end
      FT_FIXED32: begin wt = 5; v = raw % 64'h1_0000_0000; nfix = 4; end
      FT_FIXED64: begin wt = 1; v = raw; nfix = 8; end
      default:    begin wt = 0; v = raw; end
    endcase
    if (v == 0) return;
    push_varint(q, 64'(fid) * 8 + wt);
    if (nfix == 0) push_varint(q, v);
    else for (int i = 0; i < nfix; i++) q.push_back(9'((v >> (8 * i)) % 256));
  endtask

  // ---------------- driver ----------------
  task automatic issue(input logic [28:0] fid, input logic nst, input field_type_e ft,
                       input logic [63:0] raw, input logic [15:0] off, input logic [63:0] base,
                       input logic [8:0] bytes[$], input int need_mem, input int chk_mode);
    int t;
    int d0;
    int r0;
    mem_value = raw;
    exp_addr  = base + 64'(off);
    foreach (bytes[i]) exp_q.push_back(bytes[i]);
    exp_q.push_back(DONE_TOK);
    t = 0;
    @(negedge clk);
    while (!bus.ser_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("ready_timeout", 64'd0, 64'd1);
    d0 = done_cnt;
    r0 = mem_reqs;
    bus.entry         = '{field_id: fid, offset: off, nested: nst, ftype: ft};
    bus.cpp_base_addr = base;
    bus.entry_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus.entry_valid = 1'b0;
    if (chk_mode == 1) check("done_after_sample", {63'd0, bus.ser_done}, 64'd1);
    if (chk_mode == 2) begin
      repeat (2) @(posedge clk);
      #1;
      check("lat_no_byte_yet", {63'd0, bus.out_valid}, 64'd0);
      @(posedge clk);
      #1;
      check("lat_first_byte", {55'd0, bus.out_valid, bus.out_byte}, {55'd0, 1'b1, 8'h08});
    end
    t = 0;
    while (done_cnt == d0 && t < 400) begin @(negedge clk); #1; t++; end
    if (t >= 400) check("done_timeout", 64'd0, 64'd1);
    check("mem_req_count", 64'(mem_reqs - r0), 64'(need_mem));
  endtask

  logic [8:0] lst[$];
  int         nm;

  initial begin
    bus.entry         = '0;
    bus.entry_valid   = 1'b0;
    bus.cpp_base_addr = 64'd0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ser_ready", {63'd0, bus.ser_ready}, 64'd1);
    check("rst_ser_done",  {63'd0, bus.ser_done},  64'd0);
    check("rst_mem_req",   {63'd0, bus.mem_req},   64'd0);
    check("rst_mem_addr",  bus.mem_addr,           64'd0);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_out_byte",  {56'd0, bus.out_byte},  64'd0);
    reset = 1'b0;

    // Field 1 varint 150 with latency check
    lst.delete(); lst.push_back(9'h08); lst.push_back(9'h96); lst.push_back(9'h01);
    issue(29'd1, 1'b0, FT_VARINT64, 64'd150, 16'h0010, 64'h1000, lst, 1, 2);
    // Field 2 sint64 -1
    lst.delete(); lst.push_back(9'h10); lst.push_back(9'h01);
    issue(29'd2, 1'b0, FT_SINT64, 64'hFFFF_FFFF_FFFF_FFFF, 16'h0018, 64'h2000, lst, 1, 0);
    // Field 3 fixed32
    lst.delete(); lst.push_back(9'h1D); lst.push_back(9'h78); lst.push_back(9'h56);
    lst.push_back(9'h34); lst.push_back(9'h12);
    issue(29'd3, 1'b0, FT_FIXED32, 64'hAAAA_BBBB_1234_5678, 16'hFFFF, 64'hFFFF_FFFF_FFFF_FFF0, lst, 1, 0);
    // Field 4 all-ones varint with toggling out_ready
    ready_mode = 1;
    lst.delete(); lst.push_back(9'h20);
    for (int i = 0; i < 9; i++) lst.push_back(9'hFF);
    lst.push_back(9'h01);
    issue(29'd4, 1'b0, FT_VARINT64, 64'hFFFF_FFFF_FFFF_FFFF, 16'h0008, 64'h3000, lst, 1, 0);
    ready_mode = 0;
    // field_id 0 and nested: no fetch, no bytes
    lst.delete();
    issue(29'd0, 1'b0, FT_VARINT64, 64'd7, 16'h0000, 64'h4000, lst, 0, 1);
    issue(29'd9, 1'b1, FT_FIXED64, 64'd7, 16'h0000, 64'h4000, lst, 0, 1);
    // Default value elision
    issue(29'd5, 1'b0, FT_VARINT64, 64'd0, 16'h0020, 64'h5000, lst, 1, 0);
    issue(29'd6, 1'b0, FT_FIXED32, 64'hDEAD_0000_0000_0000, 16'h0028, 64'h5000, lst, 1, 0);

    // Reset during FETCH, then a late mem_rvalid that must be ignored
    mem_hold = 1'b1;
    @(negedge clk);
    bus.entry         = '{field_id: 29'd7, offset: 16'd0, nested: 1'b0, ftype: FT_VARINT64};
    bus.entry_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus.entry_valid = 1'b0;
    @(posedge clk);
    #1;
    check("fetch_mem_req", {63'd0, bus.mem_req}, 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_fetch_idle", {63'd0, bus.ser_ready}, 64'd1);
    check("rst_fetch_req",  {63'd0, bus.mem_req},   64'd0);
    mem_hold   = 1'b0;
    late_pulse = 1'b1;
    @(posedge clk);
    #1;
    late_pulse = 1'b0;
    nm = done_cnt;
    repeat (5) @(posedge clk);
    #1;
    check("late_rvalid_ignored", {63'd0, bus.ser_ready}, 64'd1);
    check("late_no_done", 64'(done_cnt - nm), 64'd0);

    // Randomized entries against the reference model
    ready_mode = 2;
    for (int n = 0; n < 40; n++) begin
      logic [28:0] fid;
      logic        nst;
      field_type_e ft;
      logic [63:0] raw;
      case ($urandom_range(0, 9))
        0:       fid = 29'd0;
        1, 2, 3: fid = 29'($urandom_range(1, 15));
        default: fid = 29'($urandom_range(1, 32'h1FFF_FFFF));
      endcase
      nst = ($urandom_range(0, 9) == 0);
      ft  = field_type_e'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       raw = 64'd0;
        1:       raw = 64'($urandom_range(0, 300));
        2:       raw = 64'hFFFF_FFFF_FFFF_FFFF;
        3:       raw = 64'd0 - 64'($urandom_range(1, 1000));
        default: raw = {$urandom, $urandom};
      endcase
      mem_delay = $urandom_range(1, 3);
      model(fid, nst, ft, raw, lst, nm);
      issue(fid, nst, ft, raw, 16'($urandom), {$urandom, $urandom}, lst, nm, 0);
    end

    nm = 0;
    while (exp_q.size() != 0 && nm < 500) begin @(negedge clk); nm++; end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
